// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer.
//   fetch_state_e  : fetch controller states
//   ILEN_C / ILEN_N: byte lengths of compressed / normal instructions
//   is_compressed(): classifies an instruction by its two low opcode bits
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        KILL,
        OUT
    } fetch_state_e;

    localparam logic [31:0] ILEN_C = 32'd2;
    localparam logic [31:0] ILEN_N = 32'd4;

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_pc_incr.sv
// pc_incr: combinational sequential-PC adder, wraps mod 2^32.
//   pc      in  32  current PC
//   c       in  1   1 = compressed instruction at pc
//   next_pc out 32  pc + 2 (c=1) or pc + 4 (c=0)
module pc_incr
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        c,
    output logic [31:0] next_pc
);

    assign next_pc = pc + (c ? ILEN_C : ILEN_N);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: instruction fetch sequencer owning the fetch PC.
//   clk, rstn                  clock, async active-low reset
//   fetch_en                   allow new requests (0 = drain to IDLE)
//   jump_en_l1 / jump_addr_l1  decode redirect
//   jump_en_l2 / jump_addr_l2  execute redirect (wins over l1)
//   imem_req / imem_addr       single-outstanding fetch request, address = pc
//   imem_gnt                   request accepted
//   imem_rvalid / imem_rdata   response (one per grant)
//   if_valid / if_ready        handshake towards decode
//   if_ins / if_pc / if_ins_c  fetched instruction, its PC, compressed flag
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic        jump_en_l1,
    input  logic [31:0] jump_addr_l1,
    input  logic        jump_en_l2,
    input  logic [31:0] jump_addr_l2,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        if_ins_c
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  ins_n, ins_pc_n;
    logic         ins_c_n;
    logic         redir;
    logic [31:0]  tgt;
    logic [31:0]  seq_pc;

    assign redir = jump_en_l1 | jump_en_l2;
    assign tgt   = (jump_en_l2 ? jump_addr_l2 : jump_addr_l1) & ~32'd1;

    pc_incr u_pc_incr (
        .pc      (pc),
        .c       (if_ins_c),
        .next_pc (seq_pc)
    );

    // Request and valid are pure state decodes, so async reset clears them at once.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign if_valid  = (state == OUT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_ins   <= '0;
            if_pc    <= RESET_PC;
            if_ins_c <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            if_ins   <= ins_n;
            if_pc    <= ins_pc_n;
            if_ins_c <= ins_c_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ins_n    = if_ins;
        ins_pc_n = if_pc;
        ins_c_n  = if_ins_c;
        unique case (state)
            IDLE: begin
                if (redir)         pc_n = tgt;
                else if (fetch_en) state_n = REQ;
            end
            REQ: begin
                if (redir) begin
                    pc_n = tgt;
                    // A granted request still owes a response that must be discarded.
                    if (imem_gnt) state_n = KILL;
                end else if (imem_gnt) begin
                    state_n = WAIT;
                end else if (!fetch_en) begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (redir) begin
                    pc_n    = tgt;
                    state_n = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    ins_n    = imem_rdata;
                    ins_pc_n = pc;
                    ins_c_n  = is_compressed(imem_rdata[1:0]);
                    state_n  = OUT;
                end
            end
            KILL: begin
                if (redir) pc_n = tgt;
                if (imem_rvalid) state_n = fetch_en ? REQ : IDLE;
            end
            OUT: begin
                // pc still equals if_pc here, so seq_pc is the next sequential address.
                if (redir) begin
                    pc_n    = tgt;
                    state_n = fetch_en ? REQ : IDLE;
                end else if (if_ready) begin
                    pc_n    = seq_pc;
                    state_n = fetch_en ? REQ : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_en = 1'b0;
    logic        jump_en_l1 = 1'b0;
    logic [31:0] jump_addr_l1 = '0;
    logic        jump_en_l2 = 1'b0;
    logic [31:0] jump_addr_l2 = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_ins_c;

    // memory model controls
    logic        gnt_en = 1'b1;
    logic        rv_en = 1'b1;
    logic        pending;
    logic [31:0] lat_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fetch_en     (fetch_en),
        .jump_en_l1   (jump_en_l1),
        .jump_addr_l1 (jump_addr_l1),
        .jump_en_l2   (jump_en_l2),
        .jump_addr_l2 (jump_addr_l2),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_ins       (if_ins),
        .if_pc        (if_pc),
        .if_ins_c     (if_ins_c)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h0000_4501;
            32'h0000_0006: return 32'h00A0_0093;
            32'hFFFF_FFFE: return 32'h0000_0001;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pending & rv_en;
    assign imem_rdata  = mem_word(lat_addr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending  <= 1'b0;
            lat_addr <= '0;
        end else if (imem_req && imem_gnt) begin
            pending  <= 1'b1;
            lat_addr <= imem_addr;
        end else if (imem_rvalid) begin
            pending  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_seen"}, {31'b0, imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, {31'b0, if_valid}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] h_ins, h_pc;

        // reset values
        #2;
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_ins",   if_ins, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_c",     {31'b0, if_ins_c}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        fetch_en = 1'b1;

        // first 32-bit fetch at RESET_PC
        wait_req("t1");
        check("t1_addr", imem_addr, 32'h0);
        wait_valid("t1", n);
        check("t1_latency", n, 32'd2);
        check("t1_ins", if_ins, 32'h0000_0013);
        check("t1_pc", if_pc, 32'h0);
        check("t1_c", {31'b0, if_ins_c}, 32'd0);
        wait_req("t1n");
        check("t1_next_addr", imem_addr, 32'h4);

        // compressed then 32-bit
        wait_valid("t2a", n);
        check("t2_c", {31'b0, if_ins_c}, 32'd1);
        check("t2_ins16", {16'b0, if_ins[15:0]}, 32'h4501);
        check("t2_pc", if_pc, 32'h4);
        wait_req("t2a");
        check("t2_addr6", imem_addr, 32'h6);
        wait_valid("t2b", n);
        check("t2b_c", {31'b0, if_ins_c}, 32'd0);
        check("t2b_ins", if_ins, 32'h00A0_0093);
        check("t2b_pc", if_pc, 32'h6);
        wait_req("t2b");
        check("t2_addrA", imem_addr, 32'hA);

        // simultaneous l1/l2 redirect in WAIT, l2 wins, stale response dropped
        rv_en = 1'b0;
        @(negedge clk);
        check("t3_wait_noreq", {31'b0, imem_req}, 32'd0);
        jump_en_l1 = 1'b1; jump_addr_l1 = 32'h100;
        jump_en_l2 = 1'b1; jump_addr_l2 = 32'h200;
        @(negedge clk);
        jump_en_l1 = 1'b0; jump_en_l2 = 1'b0;
        check("t3_kill_valid", {31'b0, if_valid}, 32'd0);
        check("t3_kill_addr", imem_addr, 32'h200);
        rv_en = 1'b1;
        @(negedge clk);
        check("t3_drop_valid", {31'b0, if_valid}, 32'd0);
        check("t3_req", {31'b0, imem_req}, 32'd1);
        check("t3_addr", imem_addr, 32'h200);

        // backpressure in OUT
        if_ready = 1'b0;
        wait_valid("t4", n);
        check("t4_pc", if_pc, 32'h200);
        h_ins = if_ins;
        h_pc  = if_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'b0, if_valid}, 32'd1);
            check("t4_hold_ins", if_ins, h_ins);
            check("t4_hold_pc", if_pc, h_pc);
            check("t4_hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        @(negedge clk);
        check("t4_single_xfer", {31'b0, if_valid}, 32'd0);
        check("t4_req", {31'b0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h204);

        // redirect same cycle as grant, then second redirect inside KILL
        rv_en = 1'b0;
        jump_en_l1 = 1'b1; jump_addr_l1 = 32'h250;
        @(negedge clk);
        check("t5_kill_noreq", {31'b0, imem_req}, 32'd0);
        check("t5_kill_addr", imem_addr, 32'h250);
        jump_addr_l1 = 32'h300;
        @(negedge clk);
        jump_en_l1 = 1'b0;
        check("t5_kill_addr2", imem_addr, 32'h300);
        check("t5_still_kill", {31'b0, imem_req}, 32'd0);
        rv_en = 1'b1;
        @(negedge clk);
        check("t5_req", {31'b0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h300);
        check("t5_valid", {31'b0, if_valid}, 32'd0);

        // reset asserted during WAIT
        rv_en = 1'b0;
        @(negedge clk);
        check("t6_wait_noreq", {31'b0, imem_req}, 32'd0);
        rstn = 1'b0;
        #1;
        check("t6_rst_addr", imem_addr, 32'h0);
        check("t6_rst_valid", {31'b0, if_valid}, 32'd0);
        check("t6_rst_pc", if_pc, 32'h0);
        check("t6_rst_ins", if_ins, 32'h0);
        fetch_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rv_en = 1'b1;
        @(negedge clk);
        jump_en_l1 = 1'b1; jump_addr_l1 = 32'h101;
        @(negedge clk);
        jump_en_l1 = 1'b0;
        check("t6_idle_noreq", {31'b0, imem_req}, 32'd0);
        check("t6_odd_addr", imem_addr, 32'h100);
        fetch_en = 1'b1;
        wait_req("t6");
        check("t6_req_addr", imem_addr, 32'h100);

        // redirect in OUT with if_ready=1 drops held ins; PC wrap
        wait_valid("t7a", n);
        jump_en_l2 = 1'b1; jump_addr_l2 = 32'hFFFF_FFFE;
        @(negedge clk);
        jump_en_l2 = 1'b0;
        check("t7_dropped", {31'b0, if_valid}, 32'd0);
        check("t7_addr", imem_addr, 32'hFFFF_FFFE);
        wait_valid("t7b", n);
        check("t7_c", {31'b0, if_ins_c}, 32'd1);
        check("t7_pc", if_pc, 32'hFFFF_FFFE);
        wait_req("t7");
        check("t7_wrap", imem_addr, 32'h0);

        // drain to IDLE with fetch_en=0
        wait_valid("t8", n);
        fetch_en = 1'b0;
        @(negedge clk);
        check("t8_noreq", {31'b0, imem_req}, 32'd0);
        check("t8_valid", {31'b0, if_valid}, 32'd0);
        check("t8_addr", imem_addr, 32'h4);
        @(negedge clk);
        check("t8_idle", {31'b0, imem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
